valid_ready_split: RTL and testbench

Width-down transmitter for the valid/ready group stream. Accepts one packed word of BEATS samples per handshake on the upstream side and emits the samples one per beat on the downstream side, marking the final beat of each group. It is the producer that feeds the 4-sample accumulating receivers in the same datapath.

---
 rtl/valid_ready_pkg.sv | 9 +
 rtl/valid_ready_split_word_sum.sv | 23 ++
 rtl/valid_ready_split.sv | 103 ++++++++++
 tb/tb_valid_ready_split.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/valid_ready_pkg.sv
// Shared constants for the valid/ready group stream (splitter and 4-sample receivers).
package valid_ready_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned SUM_W  = DATA_W + CNT_W;

endpackage

// File: rtl/valid_ready_split_word_sum.sv
// word_sum: combinational sum of the BEATS slices of a packed word.
// Only built when SPLIT_SUM_EN is defined.
`ifdef SPLIT_SUM_EN
module word_sum #(
  parameter int unsigned DATA_W = valid_ready_pkg::DATA_W,
  parameter int unsigned BEATS  = valid_ready_pkg::BEATS
) (
  input  logic [BEATS*DATA_W-1:0]          word,
  output logic [DATA_W+$clog2(BEATS)-1:0]  sum
);

  localparam int unsigned SUM_W = DATA_W + $clog2(BEATS);

  // The result is wide enough that BEATS full-scale slices cannot overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      sum = sum + SUM_W'(word[k*DATA_W +: DATA_W]);
    end
  end

endmodule
`endif

// File: rtl/valid_ready_split.sv
// valid_ready_split: width-down transmitter, one BEATS-sample word in, one sample per beat out (LSB slice first).
// Optional feature macro: SPLIT_SUM_EN adds the registered sum_b output.
module valid_ready_split #(
  parameter int unsigned DATA_W = valid_ready_pkg::DATA_W,
  parameter int unsigned BEATS  = valid_ready_pkg::BEATS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BEATS*DATA_W-1:0]         data_in,
  input  logic                            valid_a,
  output logic                            ready_a,
  output logic                            valid_b,
  input  logic                            ready_b,
  output logic [DATA_W-1:0]               data_out,
  output logic                            last_b
`ifdef SPLIT_SUM_EN
  ,
  output logic [DATA_W+$clog2(BEATS)-1:0] sum_b
`endif
);

  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned WORD_W = BEATS * DATA_W;

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_d;
  logic              last_d;
  logic [DATA_W-1:0] data_d;
  logic              up_fire;
  logic              dn_fire;

  // A new word is taken when idle or in the same cycle the last beat leaves.
  assign ready_a = ~rst & (~valid_b | (ready_b & last_b));
  assign up_fire = valid_a & ready_a;
  assign dn_fire = valid_b & ready_b;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_b;
    last_d  = last_b;
    data_d  = data_out;
    if (up_fire) begin
      shreg_d = data_in;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = data_in[DATA_W-1:0];
    end else if (dn_fire) begin
      if (last_b) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        // shreg keeps the current beat in slice 0, so slice 1 is the next beat.
        shreg_d = shreg_q >> DATA_W;
        data_d  = shreg_q[DATA_W +: DATA_W];
        cnt_d   = cnt_q + CNT_W'(1);
        last_d  = (cnt_d == CNT_W'(BEATS - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      valid_b  <= 1'b0;
      last_b   <= 1'b0;
      data_out <= '0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      valid_b  <= valid_d;
      last_b   <= last_d;
      data_out <= data_d;
    end
  end

`ifdef SPLIT_SUM_EN
  localparam int unsigned SUM_W = DATA_W + CNT_W;

  logic [SUM_W-1:0] sum_c;

  word_sum #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_word_sum (
    .word (data_in),
    .sum  (sum_c)
  );

  // Sum is captured with the word and held for all of its beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_b <= '0;
    end else if (up_fire) begin
      sum_b <= sum_c;
    end
  end
`endif

endmodule

// File: tb/tb_valid_ready_split.sv
// Directed bench for valid_ready_split with a beat scoreboard; sum_b checked when SPLIT_SUM_EN is defined.
module tb_valid_ready_split;

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 4;
  localparam int unsigned SW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   data_in;
  logic          valid_a;
  logic          ready_a;
  logic          valid_b;
  logic          ready_b;
  logic [7:0]    data_out;
  logic          last_b;
`ifdef SPLIT_SUM_EN
  logic [SW-1:0] sum_b;
`endif

  typedef struct packed {
    logic [7:0]    d;
    logic          last;
    logic [SW-1:0] sum;
  } beat_t;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;

  valid_ready_split #(.DATA_W(DW), .BEATS(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_a  (valid_a),
    .ready_a  (ready_a),
    .valid_b  (valid_b),
    .ready_b  (ready_b),
    .data_out (data_out),
    .last_b   (last_b)
`ifdef SPLIT_SUM_EN
    ,
    .sum_b    (sum_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: score a downstream beat, record an accepted word, then move to just after the edge.
  task automatic step();
    beat_t         e;
    logic [SW-1:0] s;
    @(negedge clk);
    if (valid_b && ready_b) begin
      chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("beat_data", 32'(data_out), 32'(e.d));
        chk("beat_last", 32'(last_b), 32'(e.last));
`ifdef SPLIT_SUM_EN
        chk("beat_sum", 32'(sum_b), 32'(e.sum));
`endif
      end
    end
    if (valid_a && ready_a) begin
      s = '0;
      for (int k = 0; k < int'(NB); k++) s = s + SW'(data_in[k*8 +: 8]);
      for (int k = 0; k < int'(NB); k++) begin
        e.d    = data_in[k*8 +: 8];
        e.last = (k == int'(NB) - 1);
        e.sum  = s;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && q.size() > 0; c++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_idle", 32'(valid_b), 32'd0);
  endtask

  task automatic load(input logic [31:0] w);
    data_in = w;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    valid_a = 1'b0;
    ready_b = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    chk("rst_last_b", 32'(last_b), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd0);
`ifdef SPLIT_SUM_EN
    chk("rst_sum_b", 32'(sum_b), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_ready_a", 32'(ready_a), 32'd1);

    // Single word
    ready_b = 1'b1;
    load(32'h04030201);
    chk("t1_lat_valid", 32'(valid_b), 32'd1);
    chk("t1_beat0", 32'(data_out), 32'h01);
    chk("t1_beat0_last", 32'(last_b), 32'd0);
`ifdef SPLIT_SUM_EN
    chk("t1_sum", 32'(sum_b), 32'h00A);
`endif
    repeat (4) step();
    chk("t1_empty", 32'(q.size()), 32'd0);
    chk("t1_idle", 32'(valid_b), 32'd0);

    // Back-to-back words, no bubble
    data_in = 32'h04030201;
    valid_a = 1'b1;
    chk("t2_ready_idle", 32'(ready_a), 32'd1);
    step();
    data_in = 32'h08070605;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) valid_a = 1'b0;
      chk("t2_ready_a", 32'(ready_a), 32'((i == 4) || (i == 8)));
      chk("t2_no_bubble", 32'(valid_b), 32'd1);
      step();
    end
    chk("t2_empty", 32'(q.size()), 32'd0);
    chk("t2_idle", 32'(valid_b), 32'd0);

    // Backpressure on beat 02
    load(32'h04030201);
    step();
    ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_data", 32'(data_out), 32'h02);
      chk("t3_hold_last", 32'(last_b), 32'd0);
      chk("t3_hold_valid", 32'(valid_b), 32'd1);
      chk("t3_ready_a", 32'(ready_a), 32'd0);
      step();
    end
    ready_b = 1'b1;
    drain();

    // Maximum value
    load(32'hFFFFFFFF);
`ifdef SPLIT_SUM_EN
    chk("t4_sum", 32'(sum_b), 32'h3FC);
`endif
    chk("t4_beat0", 32'(data_out), 32'hFF);
    drain();

    // Reset mid-word
    load(32'h04030201);
    step();
    chk("t5_pre_data", 32'(data_out), 32'h02);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(valid_b), 32'd0);
    chk("t5_rst_data", 32'(data_out), 32'd0);
    chk("t5_rst_ready", 32'(ready_a), 32'd0);
    chk("t5_rst_last", 32'(last_b), 32'd0);
    q.delete();
    step();
    rst = 1'b0;
    #1;
    chk("t5_rel_ready", 32'(ready_a), 32'd1);
    chk("t5_rel_valid", 32'(valid_b), 32'd0);
    load(32'h0D0C0B0A);
    chk("t5_first", 32'(data_out), 32'h0A);
    drain();

    // Upstream held high while busy
    data_in = 32'h14131211;
    valid_a = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      data_in = 32'h24232221 + 32'(i) * 32'h10101010;
      chk("t6_ready_a", 32'(ready_a), 32'(i == 4));
      step();
    end
    valid_a = 1'b0;
    chk("t6_loaded", 32'(data_out), 32'h61);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
